// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: owns the fetch PC, keeps at most one memory
// request in flight, buffers the returned word and hands it to decode
// under a valid/ready handshake. A redirect discards whatever fetch is
// pending and restarts fetching from next_pc.
//
// state | meaning
// IDLE  | first cycle after reset, no request yet
// REQ   | request presented to memory at curr_pc
// WAIT  | request accepted, waiting for its response
// OUT   | instruction held for decode
// DROP  | accepted request made stale by redirect, discard its response
module ifu_fetch #(
   parameter int unsigned                 CPU_WIDTH = 32,
   parameter logic [CPU_WIDTH-1:0]        RESET_PC  = 32'h0000_0000,
   parameter logic [CPU_WIDTH-1:0]        NOP_INST  = 32'h0000_0013
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [CPU_WIDTH-1:0]  next_pc,
   input  logic                  redirect,
   input  logic                  stall,
   output logic [CPU_WIDTH-1:0]  curr_pc,
   output logic                  imem_req_vld,
   input  logic                  imem_req_rdy,
   output logic [CPU_WIDTH-1:0]  imem_addr,
   input  logic                  imem_rsp_vld,
   input  logic [CPU_WIDTH-1:0]  imem_rsp_data,
   output logic                  ifu_inst_vld,
   output logic [CPU_WIDTH-1:0]  ifu_inst,
   output logic [CPU_WIDTH-1:0]  ifu_inst_pc,
   input  logic                  idu_rdy
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_WAIT = 3'd2,
      S_OUT  = 3'd3,
      S_DROP = 3'd4
   } state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic [CPU_WIDTH-1:0]   req_pc;
   logic [CPU_WIDTH-1:0]   inst_q;
   logic                   fire;
   logic                   req_acc;
   logic                   pc_load;
   logic                   rsp_take;

   assign fire     = (state == S_OUT) & idu_rdy & ~stall;
   assign req_acc  = (state == S_REQ) & imem_req_rdy;
   // Redirect is ignored only in IDLE, which lasts a single cycle after reset.
   assign pc_load  = req_acc | (redirect & (state != S_IDLE));
   assign rsp_take = (state == S_WAIT) & imem_rsp_vld & ~redirect;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; redirect outranks both response capture and fire
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: state_nxt = S_REQ;
         S_REQ: begin
            if (imem_req_rdy) begin
               state_nxt = redirect ? S_DROP : S_WAIT;
            end
         end
         S_WAIT: begin
            if (redirect) begin
               state_nxt = imem_rsp_vld ? S_REQ : S_DROP;
            end else if (imem_rsp_vld) begin
               state_nxt = S_OUT;
            end
         end
         S_DROP: begin
            if (imem_rsp_vld) begin
               state_nxt = S_REQ;
            end
         end
         S_OUT: begin
            if (redirect || fire) begin
               state_nxt = S_REQ;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Outputs decoded from state; the buffered word is only visible in OUT
   always_comb begin
      imem_req_vld = (state == S_REQ);
      ifu_inst_vld = (state == S_OUT);
      ifu_inst     = (state == S_OUT) ? inst_q : NOP_INST;
   end

   assign imem_addr = curr_pc;

   // Fetch PC, accepted-request PC and instruction buffer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         curr_pc     <= RESET_PC;
         req_pc      <= RESET_PC;
         inst_q      <= NOP_INST;
         ifu_inst_pc <= RESET_PC;
      end else begin
         if (pc_load) begin
            curr_pc <= next_pc;
         end
         if (req_acc) begin
            req_pc <= curr_pc;
         end
         if (rsp_take) begin
            inst_q      <= imem_rsp_data;
            ifu_inst_pc <= req_pc;
         end
      end
   end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: memory and decode are driven step by step,
// and every output is compared against hand-computed constants.
module tb_ifu_fetch;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst_n;
   logic [31:0] next_pc;
   logic        redirect;
   logic        stall;
   logic [31:0] curr_pc;
   logic        imem_req_vld;
   logic        imem_req_rdy;
   logic [31:0] imem_addr;
   logic        imem_rsp_vld;
   logic [31:0] imem_rsp_data;
   logic        ifu_inst_vld;
   logic [31:0] ifu_inst;
   logic [31:0] ifu_inst_pc;
   logic        idu_rdy;
   logic [31:0] tgt;

   int checks;
   int failures;

   ifu_fetch #(
      .CPU_WIDTH (32),
      .RESET_PC  (32'h0000_0000),
      .NOP_INST  (NOP)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .next_pc       (next_pc),
      .redirect      (redirect),
      .stall         (stall),
      .curr_pc       (curr_pc),
      .imem_req_vld  (imem_req_vld),
      .imem_req_rdy  (imem_req_rdy),
      .imem_addr     (imem_addr),
      .imem_rsp_vld  (imem_rsp_vld),
      .imem_rsp_data (imem_rsp_data),
      .ifu_inst_vld  (ifu_inst_vld),
      .ifu_inst      (ifu_inst),
      .ifu_inst_pc   (ifu_inst_pc),
      .idu_rdy       (idu_rdy)
   );

   // PC-select mux stand-in
   assign next_pc = redirect ? tgt : curr_pc + 32'd4;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic req_v, input logic [31:0] addr,
                            input logic inst_v, input logic [31:0] inst, input logic [31:0] ipc);
      check({tag, ".req_vld"},  {31'd0, imem_req_vld}, {31'd0, req_v});
      check({tag, ".addr"},     imem_addr,             addr);
      check({tag, ".inst_vld"}, {31'd0, ifu_inst_vld}, {31'd0, inst_v});
      check({tag, ".inst"},     ifu_inst,              inst);
      check({tag, ".inst_pc"},  ifu_inst_pc,           ipc);
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      rst_n         = 1'b0;
      redirect      = 1'b0;
      stall         = 1'b0;
      tgt           = 32'h0;
      imem_req_rdy  = 1'b0;
      imem_rsp_vld  = 1'b0;
      imem_rsp_data = 32'h0;
      idu_rdy       = 1'b0;

      tick();
      tick();
      check_out("reset", 1'b0, 32'h0, 1'b0, NOP, 32'h0);
      check("reset.curr_pc", curr_pc, 32'h0);

      // release; first edge is IDLE -> REQ
      rst_n = 1'b1;
      tick();
      check_out("first_req", 1'b1, 32'h0, 1'b0, NOP, 32'h0);
      imem_req_rdy = 1'b1;
      tick();
      check_out("first_wait", 1'b0, 32'h4, 1'b0, NOP, 32'h0);
      imem_req_rdy  = 1'b0;
      imem_rsp_vld  = 1'b1;
      imem_rsp_data = 32'h0050_0093;
      tick();
      check_out("first_out", 1'b0, 32'h4, 1'b1, 32'h0050_0093, 32'h0);

      // consumed immediately, second fetch at 0x4
      imem_rsp_vld = 1'b0;
      idu_rdy      = 1'b1;
      tick();
      check_out("second_req", 1'b1, 32'h4, 1'b0, NOP, 32'h0);
      imem_req_rdy = 1'b1;
      tick();
      imem_req_rdy  = 1'b0;
      imem_rsp_vld  = 1'b1;
      imem_rsp_data = 32'h00A0_0113;
      stall         = 1'b1;
      tick();
      imem_rsp_vld = 1'b0;
      check_out("second_out", 1'b0, 32'h8, 1'b1, 32'h00A0_0113, 32'h4);

      // stall holds the instruction
      for (int i = 0; i < 4; i++) begin
         tick();
         check_out("stall_hold", 1'b0, 32'h8, 1'b1, 32'h00A0_0113, 32'h4);
      end
      stall = 1'b0;
      tick();
      check_out("post_stall_req", 1'b1, 32'h8, 1'b0, NOP, 32'h4);

      // redirect while waiting, stale response arrives 3 cycles later
      imem_req_rdy = 1'b1;
      tick();
      check_out("wait_8", 1'b0, 32'hC, 1'b0, NOP, 32'h4);
      imem_req_rdy = 1'b0;
      redirect     = 1'b1;
      tgt          = 32'h100;
      tick();
      redirect = 1'b0;
      check_out("drop_0", 1'b0, 32'h100, 1'b0, NOP, 32'h4);
      tick();
      tick();
      check_out("drop_2", 1'b0, 32'h100, 1'b0, NOP, 32'h4);
      imem_rsp_vld  = 1'b1;
      imem_rsp_data = 32'hDEAD_BEEF;
      tick();
      imem_rsp_vld = 1'b0;
      check_out("after_drop_req", 1'b1, 32'h100, 1'b0, NOP, 32'h4);
      imem_req_rdy = 1'b1;
      tick();
      imem_req_rdy  = 1'b0;
      imem_rsp_vld  = 1'b1;
      imem_rsp_data = 32'h1234_5678;
      idu_rdy       = 1'b0;
      tick();
      imem_rsp_vld = 1'b0;
      check_out("redir_out", 1'b0, 32'h104, 1'b1, 32'h1234_5678, 32'h100);
      tick();
      check_out("idu_not_rdy_hold", 1'b0, 32'h104, 1'b1, 32'h1234_5678, 32'h100);

      // redirect in OUT beats fire
      idu_rdy  = 1'b1;
      redirect = 1'b1;
      tgt      = 32'h40;
      tick();
      check_out("out_redirect", 1'b1, 32'h40, 1'b0, NOP, 32'h100);

      // redirect in REQ without acceptance retargets the request
      tgt = 32'h80;
      tick();
      check_out("req_redirect", 1'b1, 32'h80, 1'b0, NOP, 32'h100);

      // redirect together with acceptance: old address goes out, response dropped
      tgt          = 32'h200;
      imem_req_rdy = 1'b1;
      tick();
      redirect     = 1'b0;
      imem_req_rdy = 1'b0;
      check_out("acc_redirect_drop", 1'b0, 32'h200, 1'b0, NOP, 32'h100);
      imem_rsp_vld  = 1'b1;
      imem_rsp_data = 32'h0BAD_0BAD;
      tick();
      imem_rsp_vld = 1'b0;
      check_out("acc_redirect_req", 1'b1, 32'h200, 1'b0, NOP, 32'h100);

      // redirect in WAIT coinciding with the response goes straight to REQ
      imem_req_rdy = 1'b1;
      tick();
      imem_req_rdy  = 1'b0;
      redirect      = 1'b1;
      tgt           = 32'h300;
      imem_rsp_vld  = 1'b1;
      imem_rsp_data = 32'h0BAD_0002;
      tick();
      redirect     = 1'b0;
      imem_rsp_vld = 1'b0;
      check_out("wait_redir_rsp", 1'b1, 32'h300, 1'b0, NOP, 32'h100);

      // reset in WAIT clears everything immediately
      imem_req_rdy = 1'b1;
      tick();
      imem_req_rdy = 1'b0;
      check_out("pre_reset_wait", 1'b0, 32'h304, 1'b0, NOP, 32'h100);
      rst_n = 1'b0;
      #1;
      check_out("async_reset", 1'b0, 32'h0, 1'b0, NOP, 32'h0);
      imem_rsp_vld  = 1'b1;
      imem_rsp_data = 32'hFFFF_FFFF;
      tick();
      rst_n = 1'b1;
      tick();
      check_out("restart_req", 1'b1, 32'h0, 1'b0, NOP, 32'h0);
      tick();
      check_out("late_rsp_ignored", 1'b1, 32'h0, 1'b0, NOP, 32'h0);
      imem_rsp_vld = 1'b0;
      imem_req_rdy = 1'b1;
      tick();
      imem_req_rdy  = 1'b0;
      imem_rsp_vld  = 1'b1;
      imem_rsp_data = 32'h0050_0093;
      idu_rdy       = 1'b0;
      tick();
      imem_rsp_vld = 1'b0;
      check_out("restart_out", 1'b0, 32'h4, 1'b1, 32'h0050_0093, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
